fp_mul_pipe: RTL
================

Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point multiplier.
- Successor to the combinational half-precision multiplier:
  - generic exponent and mantissa widths
  - full subnormal input/output support
  - round-to-nearest-even
  - IEEE exception flags
  - valid/ready handshake with backpressure
- Sits in the FPU datapath between the operand issue logic and the result writeback arbiter.

Parameters:
- EXP_W, 5, exponent field width (5 = binary16, 8 = binary32).
- MAN_W, 10, stored fraction width (10 = binary16, 23 = binary32).
- Derived, not overridable: N = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- p  out  N  product.
- qnan, infinity, zero, subnormal, normal  out  1 each  one-hot class of p.
- invalid, overflow, underflow, inexact  out  1 each  IEEE exception flags for this result.

Behaviour:
- Reset: single clock (clk), synchronous active-high reset (rst).
  - Clears all stage valid bits.
  - out_valid=0, p=0, all class and exception flags 0.
  - in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation: all in-flight results are discarded; none is emitted afterwards.
- Pipeline: 3 stages; advance = !out_valid | out_ready; in_ready = advance.
  - Latency is exactly 3 cycles with no stall.
  - Throughput is 1 result per cycle.
  - When out_ready=0 and out_valid=1, every stage holds, p and the flags stay stable, and in_ready=0.
  - Bubbles advance normally; results are never reordered, dropped or duplicated.
- S1 (unpack/classify/multiply):
  - Classify each operand as sNaN, qNaN, inf, zero, subnormal or normal.
  - Subnormals are normalised via leading-zero count: significand shifted left, exponent = 1-BIAS-lzc.
  - Significand product width is 2*(MAN_W+1).
  - Unbiased exponent sum is signed, width EXP_W+2.
  - Sign = a[N-1]^b[N-1].
- S2 (normalise):
  - If the product MSB is set, shift right by 1 and increment the exponent.
  - If exp < 1-BIAS, shift right by (1-BIAS-exp) to denormalise, OR-ing shifted-out bits into sticky.
  - Shifts >= MAN_W+3 collapse the significand into sticky.
- S3 (round/pack/flags):
  - RNE from guard, round and sticky bits.
  - Mantissa carry-out re-increments the exponent; this also covers subnormal->normal promotion.
  - Biased exponent >= 2^EXP_W-1 gives infinity, overflow=1, inexact=1.
  - inexact = guard|round|sticky.
  - underflow = tiny (before rounding) & inexact.
- Special-case priority:
  1. Either operand sNaN: result is that operand quieted (fraction MSB set), A preferred; invalid=1.
  2. Either operand qNaN: result is that operand, A preferred; no flags.
  3. inf x zero: canonical qNaN {0, all-ones exp, 1, zeros}; invalid=1.
  4. Otherwise inf: signed infinity, no flags.
  5. Otherwise zero: signed zero, no flags.
- Special results bypass rounding, so their exception flags are exact.
- The result is never an sNaN.
- Exactly one class flag is set whenever out_valid=1; the class and exception flags are 0 when out_valid=0.

Decomposition:
- Shared package fp_pkg holds:
  - class enum (SNAN, QNAN, INF, ZERO, SUB, NORM)
  - flag struct {invalid, overflow, underflow, inexact}
  - function canonical_qnan(EXP_W, MAN_W)
  - function lzc
- Sub-module fp_unpack: one operand to {sign, signed exponent, normalised significand, class}, combinational, instantiated twice in S1.
- All pipeline registers and the handshake live in fp_mul_pipe.

Test Plan:
- Exact product: 0x3C00 x 0x4000 -> p=0x4000, normal=1, no exception flags, out_valid exactly 3 cycles after acceptance.
- Rounding: 0x3C01 x 0x3C01 -> p=0x3C02, inexact=1.
- Overflow: 0x7BFF x 0x4000 -> p=0x7C00, infinity=1, overflow=1, inexact=1.
- Subnormal tie to even: 0x0001 x 0x3800 -> p=0x0000, zero=1, underflow=1, inexact=1. Also 0x0200 x 0x4000 -> p=0x0400, normal=1, exact.
- NaN/invalid:
  - 0x7D00 x 0x3C00 -> p=0x7F00, qnan=1, invalid=1.
  - 0x7C00 x 0x8000 -> p=0x7E00, qnan=1, invalid=1.
- Handshake:
  - Issue 5 back-to-back ops with out_ready=0 for 6 cycles: in_ready drops once out_valid=1 and stays low while out_ready=0; p stays stable; after out_ready=1 all 5 results emerge in order, one per cycle.
  - Assert rst mid-stream: no stale result is emitted.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier.
//   fp_class_t     : operand / result class
//   fp_flags_t     : IEEE exception flags {invalid, overflow, underflow, inexact}
//   canonical_qnan : default quiet NaN pattern for a given format (LSB-aligned in 64 bits)
//   lzc            : leading-zero count over the low w bits of a 64-bit vector
package fp_pkg;

  typedef enum logic [2:0] {SNAN, QNAN, INF, ZERO, SUB, NORM} fp_class_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Positive sign, all-ones exponent, fraction MSB set, remaining fraction zero.
  function automatic logic [63:0] canonical_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= man_w - 1 && i < man_w + exp_w) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int lzc(input logic [63:0] v, input int w);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (i < w && !found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of one IEEE-754 operand.
//   x     : packed operand (sign, biased exponent, fraction)
//   sign  : operand sign
//   expo  : signed unbiased exponent of the normalised significand
//   sig   : significand with hidden bit at MSB (subnormals are left-normalised)
//   cls   : operand class
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0]   x,
  output logic                   sign,
  output logic signed [EXP_W+1:0] expo,
  output logic [MAN_W:0]         sig,
  output fp_class_t              cls
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;
  int               lz;

  assign sign = x[EXP_W+MAN_W];
  assign e    = x[EXP_W+MAN_W-1:MAN_W];
  assign f    = x[MAN_W-1:0];

  always_comb begin
    lz   = lzc(64'({1'b0, f}), MAN_W + 1);
    cls  = NORM;
    sig  = {1'b1, f};
    expo = (EXP_W+2)'(int'(e) - BIAS);
    if (&e) begin
      sig  = '0;
      expo = '0;
      if (f == '0)          cls = INF;
      else if (f[MAN_W-1])  cls = QNAN;
      else                  cls = SNAN;
    end else if (e == '0) begin
      if (f == '0) begin
        cls  = ZERO;
        sig  = '0;
        expo = '0;
      end else begin
        // Shift the leading one up to the hidden-bit position; the lzc
        // includes the (zero) hidden bit so the exponent is emin - lz.
        cls  = SUB;
        sig  = (MAN_W+1)'({1'b0, f} << lz);
        expo = (EXP_W+2)'(1 - BIAS - lz);
      end
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier, round-to-nearest-even.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b)
//   out_valid/out_ready : result handshake (p)
//   qnan..normal        : one-hot class of p, zero when out_valid=0
//   invalid..inexact    : exception flags of p, zero when out_valid=0
// The whole pipe advances together; a stalled output freezes every stage.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] p,
  output logic                 qnan,
  output logic                 infinity,
  output logic                 zero,
  output logic                 subnormal,
  output logic                 normal,
  output logic                 invalid,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact
);

  localparam int N    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int EW   = EXP_W + 2;

  localparam logic [N-1:0]        CQNAN  = N'(canonical_qnan(EXP_W, MAN_W));
  localparam logic [N-1:0]        QBIT   = {{(EXP_W+1){1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW:0]   EMIN_X = (EW+1)'(1 - BIAS);
  localparam logic signed [EW:0]   BIAS_X = (EW+1)'(BIAS);
  localparam logic signed [EW:0]   SHMAX  = (EW+1)'(MAN_W + 3);

  function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  function automatic logic is_ovf(input logic [EXP_W:0] ef);
    return ef >= (EXP_W+1)'((1 << EXP_W) - 1);
  endfunction

  logic adv;
  logic vld_p1, vld_p2, vld_p3;

  assign adv       = !vld_p3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // ---- S1: unpack, classify, special cases, significand multiply ----
  logic                  sa, sb;
  logic signed [EW-1:0]  ea, eb;
  logic [MAN_W:0]        ma, mb;
  fp_class_t             ca, cb;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x(a), .sign(sa), .expo(ea), .sig(ma), .cls(ca)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x(b), .sign(sb), .expo(eb), .sig(mb), .cls(cb)
  );

  logic                 sign_s1, spec_s1;
  logic [N-1:0]         spec_val_s1;
  fp_class_t            spec_cls_s1;
  fp_flags_t            spec_flg_s1;
  logic signed [EW-1:0] exp_s1;
  logic [PW-1:0]        prod_s1;

  always_comb begin
    sign_s1     = sa ^ sb;
    exp_s1      = ea + eb;
    prod_s1     = PW'(ma) * PW'(mb);
    spec_s1     = 1'b1;
    spec_val_s1 = '0;
    spec_cls_s1 = QNAN;
    spec_flg_s1 = '0;
    if (ca == SNAN) begin
      spec_val_s1         = a | QBIT;
      spec_flg_s1.invalid = 1'b1;
    end else if (cb == SNAN) begin
      spec_val_s1         = b | QBIT;
      spec_flg_s1.invalid = 1'b1;
    end else if (ca == QNAN) begin
      spec_val_s1 = a;
    end else if (cb == QNAN) begin
      spec_val_s1 = b;
    end else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
      spec_val_s1         = CQNAN;
      spec_flg_s1.invalid = 1'b1;
    end else if (ca == INF || cb == INF) begin
      spec_val_s1 = {sign_s1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_cls_s1 = INF;
    end else if (ca == ZERO || cb == ZERO) begin
      spec_val_s1 = {sign_s1, {(N-1){1'b0}}};
      spec_cls_s1 = ZERO;
    end else begin
      spec_s1     = 1'b0;
      spec_cls_s1 = NORM;
    end
  end

  logic                 sign_p1, spec_p1;
  logic [N-1:0]         spec_val_p1;
  fp_class_t            spec_cls_p1;
  fp_flags_t            spec_flg_p1;
  logic signed [EW-1:0] exp_p1;
  logic [PW-1:0]        prod_p1;

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1     <= sign_s1;
      spec_p1     <= spec_s1;
      spec_val_p1 <= spec_val_s1;
      spec_cls_p1 <= spec_cls_s1;
      spec_flg_p1 <= spec_flg_s1;
      exp_p1      <= exp_s1;
      prod_p1     <= prod_s1;
    end
  end

  // ---- S2: normalise, denormalise into guard/round/sticky ----
  logic [PW-1:0]        n_s2;
  logic [PW-2:0]        nsh_s2;
  logic signed [EW-1:0] e_s2;
  logic signed [EW:0]   ex_s2, shd_s2;
  logic                 tiny_s2, lost_s2;
  logic [EXP_W:0]       bexp_s2;

  always_comb begin
    // Product lies in [1,4); keep the hidden bit at PW-1 so no bits are lost.
    n_s2 = prod_p1 << 1;
    e_s2 = exp_p1;
    if (prod_p1[PW-1]) begin
      n_s2 = prod_p1;
      e_s2 = exp_p1 + ONE_E;
    end
    ex_s2   = e_s2;
    shd_s2  = EMIN_X - ex_s2;
    tiny_s2 = ex_s2 < EMIN_X;
    nsh_s2  = n_s2[PW-2:0];
    lost_s2 = 1'b0;
    bexp_s2 = (EXP_W+1)'(ex_s2 + BIAS_X);
    if (tiny_s2) begin
      // Biased exponent 0 with a cleared hidden bit encodes the subnormal.
      bexp_s2 = '0;
      if (shd_s2 >= SHMAX) begin
        nsh_s2  = '0;
        lost_s2 = |n_s2;
      end else begin
        nsh_s2  = (PW-1)'(n_s2 >> shd_s2);
        lost_s2 = ((n_s2 >> shd_s2) << shd_s2) != n_s2;
      end
    end
  end

  logic                 sign_p2, spec_p2, tiny_p2;
  logic [N-1:0]         spec_val_p2;
  fp_class_t            spec_cls_p2;
  fp_flags_t            spec_flg_p2;
  logic [EXP_W:0]       bexp_p2;
  logic [MAN_W-1:0]     frac_p2;
  logic                 g_p2, r_p2, s_p2;

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p2     <= sign_p1;
      spec_p2     <= spec_p1;
      spec_val_p2 <= spec_val_p1;
      spec_cls_p2 <= spec_cls_p1;
      spec_flg_p2 <= spec_flg_p1;
      tiny_p2     <= tiny_s2;
      bexp_p2     <= bexp_s2;
      frac_p2     <= nsh_s2[PW-2 -: MAN_W];
      g_p2        <= nsh_s2[MAN_W];
      r_p2        <= nsh_s2[MAN_W-1];
      s_p2        <= |nsh_s2[MAN_W-2:0] | lost_s2;
    end
  end

  // ---- S3: round, pack, classify, flags ----
  logic [EXP_W+MAN_W:0] sum_s3;
  logic [EXP_W:0]       efld_s3;
  logic                 inx_s3;
  logic [N-1:0]         p_s3;
  fp_class_t            cls_s3;
  fp_flags_t            flg_s3;

  always_comb begin
    // Rounding into the packed {exponent, fraction} word lets a mantissa
    // carry bump the exponent, including subnormal -> normal promotion.
    sum_s3  = {bexp_p2, frac_p2} + (EXP_W+MAN_W+1)'(rne_inc(frac_p2[0], g_p2, r_p2, s_p2));
    efld_s3 = sum_s3[EXP_W+MAN_W:MAN_W];
    inx_s3  = g_p2 | r_p2 | s_p2;
    p_s3    = {sign_p2, sum_s3[EXP_W+MAN_W-1:0]};
    flg_s3  = '0;
    if (efld_s3 == '0) cls_s3 = (sum_s3[MAN_W-1:0] == '0) ? ZERO : SUB;
    else               cls_s3 = NORM;
    if (is_ovf(efld_s3)) begin
      p_s3            = {sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      cls_s3          = INF;
      flg_s3.overflow = 1'b1;
      flg_s3.inexact  = 1'b1;
    end else begin
      flg_s3.inexact   = inx_s3;
      flg_s3.underflow = tiny_p2 & inx_s3;
    end
    if (spec_p2) begin
      p_s3   = spec_val_p2;
      cls_s3 = spec_cls_p2;
      flg_s3 = spec_flg_p2;
    end
  end

  logic [N-1:0] p_p3;
  fp_class_t    cls_p3;
  fp_flags_t    flg_p3;

  always_ff @(posedge clk) begin
    if (adv) begin
      p_p3   <= p_s3;
      cls_p3 <= cls_s3;
      flg_p3 <= flg_s3;
    end
  end

  assign p         = vld_p3 ? p_p3 : '0;
  assign qnan      = vld_p3 && (cls_p3 == QNAN);
  assign infinity  = vld_p3 && (cls_p3 == INF);
  assign zero      = vld_p3 && (cls_p3 == ZERO);
  assign subnormal = vld_p3 && (cls_p3 == SUB);
  assign normal    = vld_p3 && (cls_p3 == NORM);
  assign invalid   = vld_p3 && flg_p3.invalid;
  assign overflow  = vld_p3 && flg_p3.overflow;
  assign underflow = vld_p3 && flg_p3.underflow;
  assign inexact   = vld_p3 && flg_p3.inexact;

endmodule
